text_line_streamer: RTL and testbench

Reader for the text ROM (`memory_chars`) and the line table (`line_mapper`). On a start request for a line index, it looks up the line's start address and word count, then fetches each 16-bit word. It emits the two packed characters high byte first on a byte stream with a valid/ready handshake, optionally appending CR LF. It sits between the ROM pair (instantiated alongside it, both combinational) and the serial or display sink.

---
 rtl/text_line_streamer.sv | 116 +++++++++++
 tb/tb_text_line_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_streamer.sv
// Streams one line of packed text from the character ROM as bytes, high byte first,
// using the line table to find the line's start word and length.
module text_line_streamer #(
  parameter int LINE_W      = 8,
  parameter int ADDR_W      = 9,
  parameter int LEN_W       = 9,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LINE_W-1:0]       line_sel,
  output logic                    busy,
  output logic                    done,
  output logic [LINE_W-1:0]       map_line,
  input  logic [ADDR_W+LEN_W-1:0] map_addr,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [15:0]             mem_dout,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_HI     = 3'd3;
  localparam logic [2:0] S_LO     = 3'd4;
  localparam logic [2:0] S_CR     = 3'd5;
  localparam logic [2:0] S_LF     = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  // Where a line goes once its text is exhausted.
  localparam logic [2:0] S_TAIL = APPEND_CRLF ? S_CR : S_DONE;

  logic [2:0]        state_q,     state_d;
  logic [LINE_W-1:0] map_line_q,  map_line_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [15:0]       word_q,      word_d;

  logic [LEN_W-1:0]  map_count;
  logic              handshake;

  assign map_count = map_addr[ADDR_W+LEN_W-1:ADDR_W];
  assign handshake = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    map_line_d  = map_line_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          map_line_d = line_sel;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        mem_addr_d  = map_addr[ADDR_W-1:0];
        remaining_d = map_count;
        state_d     = (map_count == '0) ? S_TAIL : S_FETCH;
      end
      S_FETCH: begin
        word_d      = mem_dout;
        mem_addr_d  = mem_addr_q + ADDR_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        state_d     = S_HI;
      end
      S_HI: if (handshake) state_d = S_LO;
      S_LO: if (handshake) state_d = (remaining_q != '0) ? S_FETCH : S_TAIL;
      S_CR: if (handshake) state_d = S_LF;
      S_LF: if (handshake) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      map_line_q  <= '0;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      map_line_q  <= map_line_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
    end
  end

  // Outputs decode straight from state so valid/data cannot change during a stall.
  always_comb begin
    out_data = 8'h00;
    case (state_q)
      S_HI:    out_data = word_q[15:8];
      S_LO:    out_data = word_q[7:0];
      S_CR:    out_data = 8'h0D;
      S_LF:    out_data = 8'h0A;
      default: out_data = 8'h00;
    endcase
  end

  assign out_valid = (state_q == S_HI) || (state_q == S_LO) ||
                     (state_q == S_CR) || (state_q == S_LF);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign map_line  = map_line_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_text_line_streamer.sv
// Bench for text_line_streamer: stub ROM/line table, reference byte model, random ready.
module tb_text_line_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  line_sel = 8'd0;
  logic        busy, done;
  logic [7:0]  map_line;
  logic [17:0] map_addr;
  logic [8:0]  mem_addr;
  logic [15:0] mem_dout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [17:0] map_tbl [256];
  logic [15:0] rom [512];

  assign map_addr = map_tbl[map_line];
  assign mem_dout = rom[mem_addr];

  text_line_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_sel(line_sel),
    .busy(busy), .done(done), .map_line(map_line), .map_addr(map_addr),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int first_valid, done_cnt, addr_moves, stall_err, timed_out, busy_after;

  // Reference: the line is count words from the start address (wrapping), hi byte first, then CR LF.
  function automatic void build_exp(input int line);
    int cnt, sa;
    logic [15:0] w;
    exp_q.delete();
    cnt = int'(map_tbl[line][17:9]);
    sa  = int'(map_tbl[line][8:0]);
    for (int i = 0; i < cnt; i++) begin
      w = rom[(sa + i) % 512];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic run_line(input int line, input bit rnd_ready, input bit inject);
    int cyc;
    bit prev_stall, seen_done;
    logic [7:0] prev_data;
    logic [8:0] prev_addr;
    got_q.delete();
    first_valid = -1; done_cnt = 0; addr_moves = 0; stall_err = 0;
    timed_out = 0; busy_after = 0;
    prev_stall = 0; seen_done = 0; cyc = 0;
    prev_data = 8'h00; prev_addr = 9'd0;
    @(negedge clk);
    line_sel = 8'(line);
    start = 1'b1;
    while (!seen_done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc > 300) begin
        timed_out = 1;
        break;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_err++;
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        if (inject) begin
          line_sel = 8'd5;
          start = 1'b1;
        end
      end
      if (cyc > 2 && mem_addr !== prev_addr) addr_moves++;
      prev_addr = mem_addr;
      if (done) begin
        done_cnt++;
        seen_done = 1;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
      if (busy || out_valid) busy_after = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", done); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    nvec++; if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h exp=00", out_data); end
    nvec++; if (mem_addr !== 9'd0) begin nerr++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
    nvec++; if (map_line !== 8'd0) begin nerr++; $display("FAIL reset_map_line got=%0d exp=0", map_line); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    map_tbl[0] = {9'd2, 9'd0};
    rom[0] = 16'h3131;
    rom[1] = 16'h7320;
    build_exp(0);
    run_line(0, 1'b0, 1'b0);
    nvec++; if (timed_out != 0) begin nerr++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
    nvec++; if (first_valid != 3) begin nerr++; $display("FAIL basic_latency got=%0d exp=3", first_valid); end
    nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    nvec++; if (busy_after != 0) begin nerr++; $display("FAIL basic_busy_after got=%0d exp=0", busy_after); end
    nvec++; if (got_q.size() != 6) begin nerr++; $display("FAIL basic_len got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    build_exp(0);
    run_line(0, 1'b1, 1'b0);
    nvec++; if (stall_err != 0) begin nerr++; $display("FAIL stall_stable got=%0d exp=0", stall_err); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty();
    map_tbl[3] = {9'd0, 9'd37};
    build_exp(3);
    run_line(3, 1'b1, 1'b0);
    nvec++; if (addr_moves != 0) begin nerr++; $display("FAIL empty_addr_moves got=%0d exp=0", addr_moves); end
    nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL empty_done got=%0d exp=1", done_cnt); end
    nvec++; if (got_q.size() != 2) begin nerr++; $display("FAIL empty_len got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL empty_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    map_tbl[4] = {9'd2, 9'd511};
    rom[511] = 16'h4142;
    rom[0]   = 16'h4344;
    build_exp(4);
    run_line(4, 1'b1, 1'b0);
    nvec++; if (got_q.size() != 6) begin nerr++; $display("FAIL wrap_len got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored();
    map_tbl[5] = {9'd1, 9'd100};
    rom[100]   = 16'h5A5A;
    map_tbl[6] = {9'd3, 9'd200};
    rom[200] = 16'h6162; rom[201] = 16'h6364; rom[202] = 16'h6520;
    build_exp(6);
    run_line(6, 1'b0, 1'b1);
    nvec++; if (map_line !== 8'd6) begin nerr++; $display("FAIL ign_map_line got=%0d exp=6", map_line); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL ign_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL ign_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    build_exp(5);
    run_line(5, 1'b0, 1'b0);
    nvec++; if (first_valid != 3) begin nerr++; $display("FAIL ign_next_latency got=%0d exp=3", first_valid); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL ign_next_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL ign_next_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen_valid;
    map_tbl[7] = {9'd3, 9'd300};
    rom[300] = 16'h7071; rom[301] = 16'h7273; rom[302] = 16'h7475;
    @(negedge clk);
    line_sel = 8'd7; start = 1'b1; out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rstmid_reach_hi got=%b exp=1", out_valid); end
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rstmid_done got=%b exp=0", done); end
    nvec++; if (mem_addr !== 9'd0) begin nerr++; $display("FAIL rstmid_mem_addr got=%0d exp=0", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid++;
    end
    nvec++; if (seen_valid != 0) begin nerr++; $display("FAIL rstmid_quiet got=%0d exp=0", seen_valid); end
    build_exp(7);
    run_line(7, 1'b1, 1'b0);
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL rstmid_restart_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int line, cnt, sa;
    for (int it = 0; it < 20; it++) begin
      line = $urandom_range(8, 255);
      cnt  = $urandom_range(0, 6);
      sa   = $urandom_range(0, 511);
      for (int i = 0; i < cnt; i++) rom[(sa + i) % 512] = 16'($urandom);
      map_tbl[line] = {9'(cnt), 9'(sa)};
      build_exp(line);
      run_line(line, 1'b1, 1'b0);
      nvec++; if (timed_out != 0) begin nerr++; $display("FAIL rnd%0d_timeout got=%0d exp=0", it, timed_out); end
      nvec++; if (stall_err != 0) begin nerr++; $display("FAIL rnd%0d_stable got=%0d exp=0", it, stall_err); end
      nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL rnd%0d_done got=%0d exp=1", it, done_cnt); end
      nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL rnd%0d_len got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        nvec++;
        if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) map_tbl[i] = 18'd0;
    for (int i = 0; i < 512; i++) rom[i] = 16'h2020;
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
